// File: rtl/tc_multi.sv
// Multi-channel down-counter timer with per-channel prescaler, one-shot/auto-reload and masked sticky IRQ.
// Register reads are combinational; a write takes effect on the clock edge that samples it; IRQ updates on the same edge as PEND.
// No backpressure: the bus accepts every access in a single cycle and there is no stall path.
module tc_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int PS_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESET   = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    state_t            state    [NUM_CH];
    logic [CNT_W-1:0]  preset   [NUM_CH];
    logic [CNT_W-1:0]  count    [NUM_CH];
    logic [PS_W-1:0]   prescale [NUM_CH];
    logic [PS_W-1:0]   ps_cnt   [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] im;
    logic [NUM_CH-1:0] pend;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_preset;
    logic [NUM_CH-1:0] wr_prescale;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend_set;
    logic [NUM_CH-1:0] pend_nxt;
    logic [NUM_CH-1:0] im_nxt;

    // Address bits above the channel field are decoded by the bridge.
    logic unused_addr;
    assign unused_addr = ^Addr[29:5];

    // Channel/register decode; channel numbers >= NUM_CH match nothing.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (Addr[4:2] == 3'(i));
        end
        wr_ctrl     = (WE && Addr[1:0] == REG_CTRL)     ? hit : '0;
        wr_preset   = (WE && Addr[1:0] == REG_PRESET)   ? hit : '0;
        wr_prescale = (WE && Addr[1:0] == REG_PRESCALE) ? hit : '0;
    end

    // Tick, expiry and next PEND/IM values; a hardware set beats a software clear.
    always_comb begin
        tick     = '0;
        pend_set = '0;
        pend_nxt = '0;
        im_nxt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i]     = (ps_cnt[i] == prescale[i]);
            pend_set[i] = (state[i] == ST_CNT) && en[i] && tick[i] && (count[i] == '0);
            pend_nxt[i] = pend_set[i] | (pend[i] & ~(wr_ctrl[i] & Din[3]));
            im_nxt[i]   = wr_ctrl[i] ? Din[2] : im[i];
        end
    end

    // Combinational read mux; unmatched channels read as zero.
    always_comb begin
        Dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
                case (Addr[1:0])
                    REG_CTRL:   Dout = {28'd0, pend[i], im[i], mode[i], en[i]};
                    REG_PRESET: Dout = 32'(preset[i]);
                    REG_COUNT:  Dout = 32'(count[i]);
                    default:    Dout = 32'(prescale[i]);
                endcase
            end
        end
    end

    // Register file, per-channel FSM and registered IRQ vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en   <= '0;
            mode <= '0;
            im   <= '0;
            pend <= '0;
            IRQ  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]    <= ST_IDLE;
                preset[i]   <= '0;
                count[i]    <= '0;
                prescale[i] <= '0;
                ps_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Software CTRL write wins over the one-shot EN auto-clear.
                if (wr_ctrl[i]) begin
                    en[i]   <= Din[0];
                    mode[i] <= Din[1];
                    im[i]   <= Din[2];
                end else if (state[i] == ST_INT && en[i] && !mode[i]) begin
                    en[i] <= 1'b0;
                end
                pend[i] <= pend_nxt[i];
                IRQ[i]  <= pend_nxt[i] & im_nxt[i];

                if (wr_preset[i]) begin
                    preset[i] <= Din[CNT_W-1:0];
                end
                if (wr_prescale[i]) begin
                    prescale[i] <= Din[PS_W-1:0];
                end

                case (state[i])
                    ST_IDLE: begin
                        if (en[i]) begin
                            state[i] <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (!en[i]) begin
                            state[i] <= ST_IDLE;
                        end else begin
                            count[i]  <= preset[i];
                            ps_cnt[i] <= '0;
                            state[i]  <= ST_CNT;
                        end
                    end
                    ST_CNT: begin
                        // Disable freezes COUNT where it is; expiry without EN never sets PEND.
                        if (!en[i]) begin
                            state[i] <= ST_IDLE;
                        end else if (tick[i]) begin
                            ps_cnt[i] <= '0;
                            if (count[i] == '0) begin
                                state[i] <= ST_INT;
                            end else begin
                                count[i] <= count[i] - CNT_W'(1);
                            end
                        end else begin
                            ps_cnt[i] <= ps_cnt[i] + PS_W'(1);
                        end
                    end
                    default: begin
                        if (en[i] && mode[i]) begin
                            state[i] <= ST_LOAD;
                        end else begin
                            state[i] <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_tc_multi.sv
// Self-checking bench for tc_multi: directed scenarios plus randomized two-channel runs.
// Expected IRQ/COUNT/CTRL come from closed-form period arithmetic over the enable edge.
// Stimulus is driven 1 time unit after each rising edge; outputs are sampled there too.
module tb_tc_multi;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [1:0]  IRQ;
    logic        IRQ_any;

    int n_tests;
    int n_fail;
    int edge_n;

    // Reference model state per channel
    bit m_on   [2];
    int m_e    [2];
    int m_n    [2];
    int m_p    [2];
    int m_mode [2];
    int m_im   [2];
    int m_clr  [2];

    tc_multi #(.NUM_CH(2), .CNT_W(32), .PS_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .IRQ_any (IRQ_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        Addr = 30'(ch * 4 + r);
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        Addr = 30'(ch * 4 + r);
        #1;
        v = Dout;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            m_on[i]  = 1'b0;
            m_clr[i] = -1;
        end
    endtask

    function automatic int period_len(int ch);
        return (m_n[ch] + 1) * (m_p[ch] + 1);
    endfunction

    // Edge of the most recent PEND set at or before edge c, -1 if none.
    function automatic int last_set(int ch, int c);
        int l;
        int first;
        if (!m_on[ch]) return -1;
        l = period_len(ch);
        first = m_e[ch] + 2 + l;
        if (c < first) return -1;
        if (m_mode[ch] == 0) return first;
        return first + ((c - first) / (l + 2)) * (l + 2);
    endfunction

    function automatic bit pend_exp(int ch, int c);
        int s;
        s = last_set(ch, c);
        return (s >= 0) && (s >= m_clr[ch]);
    endfunction

    function automatic int count_exp(int ch, int c);
        int l;
        int b0;
        int off;
        if (!m_on[ch]) return 0;
        l = period_len(ch);
        b0 = m_e[ch] + 2;
        if (c < b0) return 0;
        off = (m_mode[ch] == 0) ? (c - b0) : ((c - b0) % (l + 2));
        if (off < l) return m_n[ch] - off / (m_p[ch] + 1);
        return 0;
    endfunction

    function automatic int ctrl_exp(int ch, int c);
        int en_v;
        en_v = (m_mode[ch] == 1 || c < m_e[ch] + 3 + period_len(ch)) ? 1 : 0;
        return (int'(pend_exp(ch, c)) << 3) | (m_im[ch] << 2) | (m_mode[ch] << 1) | en_v;
    endfunction

    initial begin
        logic [31:0] v;
        logic [1:0]  irq_e;
        int t;
        int rises;
        bit last;
        int rch;

        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;
        reset   = 1'b0;
        WE      = 1'b0;
        Addr    = '0;
        Din     = '0;

        // Reset state
        do_reset();
        chk("rst_irq", 32'(IRQ), 32'h0);
        for (int r = 0; r < 4; r++) begin
            rd(1, r, v);
            chk("rst_reg", v, 32'h0);
        end

        // Asynchronous reset mid-count
        wr(0, 1, 100);
        wr(0, 0, 32'h5);
        repeat (10) step();
        rd(0, 2, v);
        chk("pre_rst_count", v, 32'd92);
        reset = 1'b0;
        #1;
        chk("arst_irq", 32'(IRQ), 32'h0);
        chk("arst_irq_any", 32'(IRQ_any), 32'h0);
        rd(0, 0, v); chk("arst_ctrl", v, 32'h0);
        rd(0, 1, v); chk("arst_preset", v, 32'h0);
        rd(0, 2, v); chk("arst_count", v, 32'h0);
        reset = 1'b1;
        repeat (5) step();
        rd(0, 2, v);
        chk("post_rst_count", v, 32'h0);
        chk("post_rst_irq", 32'(IRQ), 32'h0);

        // One-shot expiry: IRQ rises 8 cycles after the EN write edge
        do_reset();
        wr(0, 1, 5);
        wr(0, 3, 0);
        wr(0, 0, 32'h5);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("oneshot_irq", 32'(IRQ[0]), (k == 8) ? 32'h1 : 32'h0);
        end
        step();
        rd(0, 0, v); chk("oneshot_ctrl", v, 32'hC);
        rd(0, 2, v); chk("oneshot_count", v, 32'h0);
        wr(0, 0, 32'h8);
        chk("oneshot_clr_irq", 32'(IRQ[0]), 32'h0);
        rd(0, 0, v); chk("oneshot_clr_ctrl", v, 32'h0);

        // Auto-reload with prescaler on channel 1
        do_reset();
        wr(1, 1, 3);
        wr(1, 3, 2);
        wr(1, 0, 32'h7);
        m_on[1] = 1'b1; m_e[1] = edge_n; m_n[1] = 3; m_p[1] = 2; m_mode[1] = 1; m_im[1] = 1;
        rises = 0;
        last  = 1'b0;
        repeat (44) begin
            if (last) begin
                wr(1, 0, 32'hF);
                m_clr[1] = edge_n;
            end else begin
                step();
            end
            chk("auto_irq", 32'(IRQ[1]), 32'(pend_exp(1, edge_n)));
            rd(1, 2, v);
            chk("auto_count", v, 32'(count_exp(1, edge_n)));
            if (IRQ[1] && !last) rises++;
            last = IRQ[1];
        end
        chk("auto_periods", 32'(rises), 32'd3);

        // Mask gating
        do_reset();
        wr(0, 1, 2);
        wr(0, 3, 1);
        wr(0, 0, 32'h1);
        repeat (10) step();
        chk("mask_irq_off", 32'(IRQ[0]), 32'h0);
        rd(0, 0, v); chk("mask_ctrl", v, 32'h8);
        wr(0, 0, 32'h5);
        chk("mask_irq_on", 32'(IRQ[0]), 32'h1);
        chk("mask_irq_any", 32'(IRQ_any), 32'h1);

        // Mid-count disable, then preset change and re-enable
        do_reset();
        wr(0, 1, 50);
        wr(0, 0, 32'h1);
        repeat (31) step();
        rd(0, 2, v); chk("mid_count_21", v, 32'd21);
        wr(0, 0, 32'h0);
        rd(0, 2, v); chk("mid_count_20", v, 32'd20);
        repeat (5) step();
        rd(0, 2, v); chk("mid_hold", v, 32'd20);
        rd(0, 0, v); chk("mid_ctrl", v, 32'h0);
        wr(0, 1, 4);
        wr(0, 0, 32'h1);
        step();
        rd(0, 2, v); chk("reload_wait", v, 32'd20);
        step();
        rd(0, 2, v); chk("reload_4", v, 32'd4);

        // PEND clear coinciding with expiry, out-of-range channel, COUNT write
        do_reset();
        wr(0, 1, 1);
        wr(0, 0, 32'h5);
        t = edge_n;
        repeat (3) step();
        chk("race_pre_irq", 32'(IRQ[0]), 32'h0);
        wr(0, 0, 32'hD);
        chk("race_edge", 32'(edge_n - t), 32'd4);
        chk("race_irq", 32'(IRQ[0]), 32'h1);
        rd(0, 0, v); chk("race_ctrl", v, 32'hD);
        step();
        rd(0, 0, v); chk("race_ctrl_idle", v, 32'hC);
        wr(2, 1, 32'h1234);
        wr(2, 0, 32'h5);
        wr(2, 3, 32'h7);
        rd(2, 1, v); chk("oor_preset", v, 32'h0);
        rd(2, 0, v); chk("oor_ctrl", v, 32'h0);
        rd(1, 1, v); chk("oor_ch1_preset", v, 32'h0);
        rd(1, 0, v); chk("oor_ch1_ctrl", v, 32'h0);
        wr(0, 2, 32'hFFFF);
        rd(0, 2, v); chk("count_wr_ignored", v, 32'h0);

        // Randomized two-channel runs against the period model
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int c = 0; c < 2; c++) begin
                m_n[c]    = $urandom_range(0, 6);
                m_p[c]    = $urandom_range(0, 3);
                m_mode[c] = $urandom_range(0, 1);
                m_im[c]   = $urandom_range(0, 1);
                wr(c, 1, 32'(m_n[c]));
                wr(c, 3, 32'(m_p[c]));
            end
            for (int c = 0; c < 2; c++) begin
                wr(c, 0, 32'((m_im[c] << 2) | (m_mode[c] << 1) | 1));
                m_on[c] = 1'b1;
                m_e[c]  = edge_n;
            end
            repeat (70) begin
                rch = $urandom_range(0, 1);
                if (m_mode[rch] == 1 && $urandom_range(0, 5) == 0) begin
                    wr(rch, 0, 32'(8 | (m_im[rch] << 2) | 2 | 1));
                    m_clr[rch] = edge_n;
                end else begin
                    step();
                end
                irq_e[0] = pend_exp(0, edge_n) && (m_im[0] == 1);
                irq_e[1] = pend_exp(1, edge_n) && (m_im[1] == 1);
                chk("rnd_irq", 32'(IRQ), 32'(irq_e));
                chk("rnd_irq_any", 32'(IRQ_any), 32'(|irq_e));
                rd(edge_n % 2, 2, v);
                chk("rnd_count", v, 32'(count_exp(edge_n % 2, edge_n)));
                rd(edge_n % 2, 0, v);
                chk("rnd_ctrl", v, 32'(ctrl_exp(edge_n % 2, edge_n)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
- Parametrised multi-channel timer/counter; next generation of the single-channel TC peripheral on the CPU bridge.
- Provides NUM_CH independent down-counters, each with:
  - a per-channel prescaler;
  - one-shot or auto-reload mode;
  - a sticky interrupt-pending flag with a mask.
- Sits on the bridge's peripheral bus. It outputs a per-channel IRQ vector and an OR-reduced IRQ, both for the hwint lines.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- CNT_W, 32, counter and preset width in bits (8..32).
- PS_W, 16, prescaler width in bits (1..16).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Addr  in  30  word address, byte-address bits [31:2].
- WE  in  1  write enable for the addressed register.
- Din  in  32  write data.
- Dout  out  32  read data for Addr; combinational.
- IRQ  out  NUM_CH  per-channel interrupt, IRQ[i] = PEND[i] & IM[i].
- IRQ_any  out  1  OR of all IRQ bits.

Behaviour:
- Address decode:
  - Register = Addr[1:0]: 0 CTRL, 1 PRESET, 2 COUNT, 3 PRESCALE.
  - Channel = Addr[4:2]; upper bits are ignored (the bridge decodes them).
  - Channel index >= NUM_CH: reads return 0, writes are ignored.
- CTRL bits:
  - [0] EN.
  - [1] MODE (0 one-shot, 1 auto-reload).
  - [2] IM.
  - [3] PEND: read-only. Writing 1 clears it; writing 0 leaves it unchanged.
  - [31:4] read as 0.
- Register access:
  - PRESET is R/W, CNT_W bits, zero-extended on read.
  - COUNT is read-only; writes are ignored.
  - PRESCALE is R/W, PS_W bits.
- Reset (reset=0, asynchronous):
  - All CTRL, PRESET, COUNT and PRESCALE registers go to 0.
  - Prescaler counters go to 0; PEND = 0; every channel state = IDLE.
  - IRQ = 0, IRQ_any = 0.
  - Dout reflects the reset register values.
  - Reset mid-count aborts immediately; no IRQ is produced.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: when EN=1, go to LOAD next cycle.
  - LOAD (one cycle): COUNT <= PRESET; prescaler counter <= 0; go to CNT.
  - CNT:
    - A tick occurs on a cycle where prescaler counter == PRESCALE; the prescaler counter then returns to 0, otherwise it increments.
    - PRESCALE=0 gives a tick every cycle.
    - On a tick with COUNT>0: COUNT <= COUNT-1.
    - On a tick with COUNT==0: go to INT.
  - INT (one cycle):
    - PEND <= 1.
    - MODE=0: EN <= 0, go to IDLE.
    - MODE=1: go to LOAD.
  - EN=0 seen in LOAD, CNT or INT: go to IDLE next cycle. COUNT holds its value and PEND is not set in that transition.
- Timing:
  - Count period is (PRESET+1)*(PRESCALE+1) CNT cycles.
  - First IRQ is asserted 2 + (PRESET+1)*(PRESCALE+1) cycles after the EN write edge.
  - PRESET=0 gives an IRQ after one tick.
  - In auto-reload, later periods take (PRESET+1)*(PRESCALE+1) + 2 cycles (LOAD and INT included).
- Write interactions:
  - A PRESET or PRESCALE write during CNT takes effect at the next LOAD; the prescaler compare uses the live PRESCALE.
  - Software CTRL write and the hardware EN clear (INT, MODE=0) in the same cycle: software value wins for EN/MODE/IM.
  - Software PEND-clear and hardware PEND-set in the same cycle: the set wins.
- Outputs:
  - IRQ is registered from PEND and IM; it drops the cycle after PEND is cleared or IM is written 0.
  - Channels are fully independent; simultaneous expiries set their own PEND bits in the same cycle.
- COUNT and CNT_W:
  - COUNT never underflows; it rests at 0 in INT/IDLE after expiry (MODE=0).
  - CNT_W<32: Din upper bits are discarded on PRESET writes.

Test Plan:
- Reset check: reset=0 while channel 0 counts, PRESET=100 -> IRQ=0, all registers read 0 immediately; after release, COUNT stays 0 and no IRQ.
- One-shot expiry: ch0 PRESET=5, PRESCALE=0, CTRL=0x5 (EN, IM) -> IRQ[0] rises 8 cycles after the write edge.
  - CTRL then reads 0xC (EN cleared, PEND set).
  - Writing CTRL=0x8 drops IRQ[0] next cycle.
- Auto-reload with prescaler: ch1 PRESET=3, PRESCALE=2, CTRL=0x7 -> PEND sets every 14 cycles, for 3 periods.
  - COUNT sequence is 3,2,1,0 with each value held 3 cycles.
- Mask gating: ch0 expires with IM=0 -> PEND=1, IRQ[0]=0.
  - Writing CTRL=0x5 (IM=1) raises IRQ[0] and IRQ_any next cycle.
- Mid-count disable and preset change: ch0 PRESET=50 counting; write CTRL EN=0 at COUNT=20 -> IDLE, COUNT holds 20, no PEND.
  - Write PRESET=4, then EN=1 -> reloads 4.
- Corner writes:
  - PEND-clear in the same cycle as expiry -> PEND remains 1.
  - Write to channel index NUM_CH -> no state change, read returns 0.
  - Write COUNT=0xFFFF -> ignored.
